// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter in front of the single SDRAM slave port.
// Round-robin with a burst cap; a release always leaves one idle cycle before the next grant.
module wshb_arbiter #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_m_cyc,
  input  logic [1:0]            i_m_stb,
  input  logic [1:0]            i_m_we,
  input  logic [2*AW-1:0]       i_m_adr,
  input  logic [2*DW-1:0]       i_m_dat_ms,
  input  logic [2*(DW/8)-1:0]   i_m_sel,
  output logic [1:0]            o_m_ack,
  output logic [DW-1:0]         o_m_dat_sm,
  output logic                  o_s_cyc,
  output logic                  o_s_stb,
  output logic                  o_s_we,
  output logic [AW-1:0]         o_s_adr,
  output logic [DW-1:0]         o_s_dat_ms,
  output logic [DW/8-1:0]       o_s_sel,
  input  logic                  i_s_ack,
  input  logic [DW-1:0]         i_s_dat_sm,
  output logic [1:0]            o_gnt
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    GntNone = 2'b00,
    GntM0   = 2'b01,
    GntM1   = 2'b10
  } gnt_e;

  gnt_e       r_gnt;
  logic       r_last;
  logic [7:0] r_cnt;

  logic       w_busy;
  logic       w_own;
  logic       w_own_req;
  logic       w_other_req;
  logic [8:0] w_cnt_inc;
  logic       w_cap_hit;

  assign w_busy      = (r_gnt != GntNone);
  assign w_own       = (r_gnt == GntM1);
  assign w_own_req   = i_m_cyc[w_own];
  assign w_other_req = i_m_cyc[~w_own];
  assign w_cnt_inc   = {1'b0, r_cnt} + 9'd1;
  // The cap is only checked on an ack, so an outstanding transfer is never cut off.
  assign w_cap_hit   = i_s_ack && (w_cnt_inc >= 9'(MAX_BURST));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt  <= GntNone;
      r_last <= 1'b0;
      r_cnt  <= 8'd0;
    end else if (!w_busy) begin
      r_cnt <= 8'd0;
      if (i_m_cyc == 2'b11) begin
        if (r_last) begin
          r_gnt  <= GntM0;
          r_last <= 1'b0;
        end else begin
          r_gnt  <= GntM1;
          r_last <= 1'b1;
        end
      end else if (i_m_cyc[0]) begin
        r_gnt  <= GntM0;
        r_last <= 1'b0;
      end else if (i_m_cyc[1]) begin
        r_gnt  <= GntM1;
        r_last <= 1'b1;
      end
    end else if (!w_own_req || (w_other_req && w_cap_hit)) begin
      r_gnt <= GntNone;
      r_cnt <= 8'd0;
    end else if (i_s_ack && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_comb begin
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_adr    = '0;
    o_s_dat_ms = '0;
    o_s_sel    = '0;
    o_m_ack    = 2'b00;
    if (w_busy) begin
      o_s_cyc = i_m_cyc[w_own];
      o_s_stb = i_m_stb[w_own];
      o_s_we  = i_m_we[w_own];
      if (w_own) begin
        o_s_adr    = i_m_adr[AW +: AW];
        o_s_dat_ms = i_m_dat_ms[DW +: DW];
        o_s_sel    = i_m_sel[SW +: SW];
        o_m_ack    = {i_s_ack, 1'b0};
      end else begin
        o_s_adr    = i_m_adr[0 +: AW];
        o_s_dat_ms = i_m_dat_ms[0 +: DW];
        o_s_sel    = i_m_sel[0 +: SW];
        o_m_ack    = {1'b0, i_s_ack};
      end
    end
  end

  assign o_m_dat_sm = i_s_dat_sm;
  assign o_gnt      = r_gnt;

endmodule
